// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter granting four requesters one at a time onto a shared
// 256-bit memory port. Each transaction is IDLE -> ISSUE -> WAIT -> DONE.
// The memory signals completion with mem_flag; a WAIT that exceeds TIMEOUT
// cycles ends with an err pulse instead of an ack pulse.
module mem_port_arbiter #(
    parameter int TIMEOUT = 15,
    parameter int NREQ    = 4
) (
    input  logic                  clk,
    input  logic                  RESET,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       rw,
    input  logic [8*NREQ-1:0]     addr,
    input  logic [256*NREQ-1:0]   wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic [NREQ-1:0]       err,
    output logic [255:0]          rdata,
    output logic                  mem_en,
    output logic                  mem_rw,
    output logic [7:0]            mem_addr,
    output logic [255:0]          mem_wdata,
    input  logic [255:0]          mem_rdata,
    input  logic                  mem_flag
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t         r_state;
    logic [1:0]     r_ptr;
    logic [1:0]     r_win;
    logic [7:0]     r_cnt;
    logic [3:0]     r_gnt;
    logic [3:0]     r_ack;
    logic [3:0]     r_err;
    logic [255:0]   r_rdata;
    logic           r_mem_en;
    logic           r_mem_rw;
    logic [7:0]     r_mem_addr;
    logic [255:0]   r_mem_wdata;

    logic           w_found;
    logic [1:0]     w_sel;
    logic [1:0]     w_idx;
    logic [7:0]     w_cnt_nxt;
    logic [7:0]     w_addr_arr  [NREQ];
    logic [255:0]   w_wdata_arr [NREQ];

    // Unpack the per-requester address and write-data buses into arrays.
    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            w_addr_arr[k]  = addr[8*k +: 8];
            w_wdata_arr[k] = wdata[256*k +: 256];
        end
    end

    // Pick the first requesting index at or above the rotating pointer.
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_ptr;
        w_idx   = 2'd0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = r_ptr + 2'(i);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end else begin
                w_found = w_found;
                w_sel   = w_sel;
            end
        end
    end

    assign w_cnt_nxt = r_cnt + 8'd1;

    // Transaction FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            r_state     <= ST_IDLE;
            r_ptr       <= 2'd0;
            r_win       <= 2'd0;
            r_cnt       <= 8'd0;
            r_gnt       <= 4'd0;
            r_ack       <= 4'd0;
            r_err       <= 4'd0;
            r_rdata     <= 256'd0;
            r_mem_en    <= 1'b0;
            r_mem_rw    <= 1'b0;
            r_mem_addr  <= 8'd0;
            r_mem_wdata <= 256'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ack <= 4'd0;
                    r_err <= 4'd0;
                    if (w_found) begin
                        // Latch everything now so later input changes cannot disturb the access.
                        r_win       <= w_sel;
                        r_gnt       <= 4'b0001 << w_sel;
                        r_mem_en    <= 1'b1;
                        r_mem_rw    <= rw[w_sel];
                        r_mem_addr  <= w_addr_arr[w_sel];
                        r_mem_wdata <= w_wdata_arr[w_sel];
                        r_state     <= ST_ISSUE;
                    end else begin
                        r_gnt    <= 4'd0;
                        r_mem_en <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    r_mem_en <= 1'b0;
                    r_state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mem_flag) begin
                        // Completion takes priority over a coincident timeout.
                        if (!r_mem_rw) begin
                            r_rdata <= mem_rdata;
                        end else begin
                            r_rdata <= r_rdata;
                        end
                        r_ack   <= r_gnt;
                        r_state <= ST_DONE;
                    end else if (w_cnt_nxt == TIMEOUT_C) begin
                        // r_err doubles as the timeout flag for the DONE cycle.
                        r_cnt   <= w_cnt_nxt;
                        r_err   <= r_gnt;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt   <= w_cnt_nxt;
                        r_state <= ST_WAIT;
                    end
                end
                ST_DONE: begin
                    r_ack   <= 4'd0;
                    r_err   <= 4'd0;
                    r_gnt   <= 4'd0;
                    r_ptr   <= r_win + 2'd1;
                    r_cnt   <= 8'd0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_gnt    <= 4'd0;
                    r_ack    <= 4'd0;
                    r_err    <= 4'd0;
                    r_mem_en <= 1'b0;
                    r_cnt    <= 8'd0;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign ack       = r_ack;
    assign err       = r_err;
    assign rdata     = r_rdata;
    assign mem_en    = r_mem_en;
    assign mem_rw    = r_mem_rw;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: expected transactions are queued
// as stimulus is driven and popped when the arbiter acks or errs.
module tb_mem_port_arbiter;

    logic           clk = 1'b0;
    logic           RESET;
    logic [3:0]     req, rw, gnt, ack, err;
    logic [31:0]    addr;
    logic [1023:0]  wdata;
    logic [255:0]   rdata, mem_wdata, mem_rdata;
    logic           mem_en, mem_rw, mem_flag;
    logic [7:0]     mem_addr;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]   gnt;
        logic [3:0]   ack;
        logic [3:0]   err;
        logic [255:0] rdata;
        logic         mem_rw;
        logic [7:0]   mem_addr;
        logic [255:0] mem_wdata;
        int           wait_cycles;
    } exp_t;

    typedef struct {
        bit           done;
        logic [3:0]   gnt;
        int           en_pulses;
        logic         mem_rw;
        logic [7:0]   mem_addr;
        logic [255:0] mem_wdata;
        logic [3:0]   ack;
        logic [3:0]   err;
        logic [255:0] rdata;
        logic [3:0]   gnt_done;
        logic [7:0]   addr_done;
        int           wait_cycles;
        logic [3:0]   gnt_idle;
        logic [3:0]   ackerr_idle;
        logic         en_idle;
    } obs_t;

    exp_t         sb[$];
    logic [255:0] exp_rdata;
    logic [255:0] wv [4];

    mem_port_arbiter #(.TIMEOUT(15), .NREQ(4)) dut (
        .clk(clk), .RESET(RESET), .req(req), .rw(rw), .addr(addr), .wdata(wdata),
        .gnt(gnt), .ack(ack), .err(err), .rdata(rdata),
        .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_flag(mem_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "watchdog");
    end

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic set_inputs();
        rw    = 4'b0000;
        addr  = {8'h40, 8'h30, 8'h20, 8'h10};
        wdata = {wv[3], wv[2], wv[1], wv[0]};
    endtask

    // Runs one transaction starting from an IDLE negedge; returns observations only.
    task automatic do_txn(input int flag_delay, input logic [255:0] rd,
                          input bit flag_in_issue, input bit scramble, output obs_t o);
        o.done = 1'b0; o.ack = 4'd0; o.err = 4'd0; o.rdata = 256'd0;
        o.gnt_done = 4'd0; o.addr_done = 8'd0; o.wait_cycles = -1;
        @(posedge clk); @(negedge clk);
        o.gnt = gnt; o.en_pulses = mem_en ? 1 : 0;
        o.mem_rw = mem_rw; o.mem_addr = mem_addr; o.mem_wdata = mem_wdata;
        if (flag_in_issue) begin
            mem_flag  = 1'b1;
            mem_rdata = ~rd;
        end
        if (scramble) begin
            req = 4'd0; rw = ~rw; addr = ~addr; wdata = ~wdata;
        end
        for (int c = 1; c <= 40 && !o.done; c++) begin
            @(posedge clk); @(negedge clk);
            if (mem_en) o.en_pulses++;
            if ((ack | err) != 4'd0) begin
                o.done = 1'b1; o.wait_cycles = c - 1;
                o.ack = ack; o.err = err; o.rdata = rdata;
                o.gnt_done = gnt; o.addr_done = mem_addr;
                mem_flag = 1'b0;
            end else begin
                mem_flag  = (c == flag_delay);
                mem_rdata = (c == flag_delay) ? rd : ~rd;
            end
        end
        @(posedge clk); @(negedge clk);
        o.gnt_idle = gnt; o.ackerr_idle = ack | err; o.en_idle = mem_en;
    endtask

    task automatic test_reset();
        RESET = 1'b0; req = 4'hF; mem_flag = 1'b1; mem_rdata = rand256();
        set_inputs();
        #2;
        checks++;
        if ({gnt, ack, err, mem_en, mem_rw, mem_addr} !== 22'd0 || rdata !== 256'd0 || mem_wdata !== 256'd0) begin
            failures++;
            $display("FAIL reset_outputs got=gnt%b ack%b err%b en%b rw%b addr%h exp=all zero", gnt, ack, err, mem_en, mem_rw, mem_addr);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (gnt !== 4'd0 || mem_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold got=gnt%b en%b exp=gnt0000 en0", gnt, mem_en);
        end
        req = 4'd0; mem_flag = 1'b0; RESET = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (gnt !== 4'd0 || mem_en !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_req got=gnt%b en%b exp=gnt0000 en0", gnt, mem_en);
        end
    endtask

    task automatic test_round_robin();
        obs_t o; exp_t e; logic [255:0] rd;
        int order [5] = '{0, 1, 2, 3, 0};
        req = 4'hF;
        for (int k = 0; k < 5; k++) begin
            rd = rand256();
            exp_rdata = rd;
            sb.push_back('{gnt: 4'd1 << order[k], ack: 4'd1 << order[k], err: 4'd0, rdata: rd,
                           mem_rw: 1'b0, mem_addr: 8'(8'h10 * (order[k] + 1)), mem_wdata: wv[order[k]], wait_cycles: 1});
            do_txn(1, rd, 1'b0, 1'b0, o);
            e = sb.pop_front();
            checks++;
            if (!o.done || o.gnt !== e.gnt || o.ack !== e.ack || o.err !== e.err) begin
                failures++;
                $display("FAIL rr_grant[%0d] got=done%0d gnt%b ack%b err%b exp=gnt%b ack%b err%b", k, o.done, o.gnt, o.ack, o.err, e.gnt, e.ack, e.err);
            end
            checks++;
            if (o.rdata !== e.rdata || o.mem_addr !== e.mem_addr || o.wait_cycles != e.wait_cycles) begin
                failures++;
                $display("FAIL rr_data[%0d] got=addr%h wait%0d rdata%h exp=addr%h wait%0d rdata%h", k, o.mem_addr, o.wait_cycles, o.rdata, e.mem_addr, e.wait_cycles, e.rdata);
            end
        end
        req = 4'd0;
    endtask

    task automatic test_single_read();
        obs_t o; exp_t e; logic [255:0] x;
        x = rand256();
        exp_rdata = x;
        req = 4'b0001;
        sb.push_back('{gnt: 4'b0001, ack: 4'b0001, err: 4'd0, rdata: x, mem_rw: 1'b0,
                       mem_addr: 8'h10, mem_wdata: wv[0], wait_cycles: 2});
        do_txn(2, x, 1'b0, 1'b0, o);
        req = 4'd0;
        e = sb.pop_front();
        checks++;
        if (o.en_pulses != 1 || o.mem_addr !== e.mem_addr || o.mem_rw !== e.mem_rw) begin
            failures++;
            $display("FAIL read_issue got=pulses%0d addr%h rw%b exp=pulses1 addr%h rw%b", o.en_pulses, o.mem_addr, o.mem_rw, e.mem_addr, e.mem_rw);
        end
        checks++;
        if (!o.done || o.ack !== e.ack || o.err !== e.err || o.gnt_done !== e.gnt || o.wait_cycles != e.wait_cycles) begin
            failures++;
            $display("FAIL read_ack got=ack%b err%b gnt%b wait%0d exp=ack%b err%b gnt%b wait%0d", o.ack, o.err, o.gnt_done, o.wait_cycles, e.ack, e.err, e.gnt, e.wait_cycles);
        end
        checks++;
        if (o.rdata !== e.rdata) begin
            failures++;
            $display("FAIL read_rdata got=%h exp=%h", o.rdata, e.rdata);
        end
        checks++;
        if (o.gnt_idle !== 4'd0 || o.ackerr_idle !== 4'd0 || o.en_idle !== 1'b0) begin
            failures++;
            $display("FAIL read_after got=gnt%b ackerr%b en%b exp=gnt0000 ackerr0000 en0", o.gnt_idle, o.ackerr_idle, o.en_idle);
        end
    endtask

    task automatic test_write();
        obs_t o; exp_t e;
        req = 4'b0100; rw = 4'b0100;
        sb.push_back('{gnt: 4'b0100, ack: 4'b0100, err: 4'd0, rdata: exp_rdata, mem_rw: 1'b1,
                       mem_addr: 8'h30, mem_wdata: wv[2], wait_cycles: 3});
        do_txn(3, rand256(), 1'b1, 1'b1, o);
        set_inputs();
        e = sb.pop_front();
        checks++;
        if (o.mem_rw !== e.mem_rw || o.mem_wdata !== e.mem_wdata || o.gnt !== e.gnt) begin
            failures++;
            $display("FAIL write_issue got=rw%b gnt%b wdata%h exp=rw%b gnt%b wdata%h", o.mem_rw, o.gnt, o.mem_wdata, e.mem_rw, e.gnt, e.mem_wdata);
        end
        checks++;
        if (!o.done || o.ack !== e.ack || o.err !== e.err || o.wait_cycles != e.wait_cycles || o.addr_done !== e.mem_addr) begin
            failures++;
            $display("FAIL write_done got=ack%b err%b wait%0d addr%h exp=ack%b err%b wait%0d addr%h", o.ack, o.err, o.wait_cycles, o.addr_done, e.ack, e.err, e.wait_cycles, e.mem_addr);
        end
        checks++;
        if (o.rdata !== e.rdata) begin
            failures++;
            $display("FAIL write_rdata got=%h exp=%h", o.rdata, e.rdata);
        end
    endtask

    task automatic test_timeout();
        obs_t o; exp_t e; logic [255:0] rd;
        req = 4'hF;
        sb.push_back('{gnt: 4'b1000, ack: 4'd0, err: 4'b1000, rdata: exp_rdata, mem_rw: 1'b0,
                       mem_addr: 8'h40, mem_wdata: wv[3], wait_cycles: 15});
        do_txn(0, rand256(), 1'b0, 1'b0, o);
        e = sb.pop_front();
        checks++;
        if (!o.done || o.gnt !== e.gnt || o.err !== e.err || o.ack !== e.ack || o.wait_cycles != e.wait_cycles) begin
            failures++;
            $display("FAIL timeout_err got=gnt%b ack%b err%b wait%0d exp=gnt%b ack%b err%b wait%0d", o.gnt, o.ack, o.err, o.wait_cycles, e.gnt, e.ack, e.err, e.wait_cycles);
        end
        checks++;
        if (o.rdata !== e.rdata || o.ackerr_idle !== 4'd0) begin
            failures++;
            $display("FAIL timeout_after got=rdata%h ackerr%b exp=rdata%h ackerr0000", o.rdata, o.ackerr_idle, e.rdata);
        end
        rd = rand256();
        exp_rdata = rd;
        sb.push_back('{gnt: 4'b0001, ack: 4'b0001, err: 4'd0, rdata: rd, mem_rw: 1'b0,
                       mem_addr: 8'h10, mem_wdata: wv[0], wait_cycles: 2});
        do_txn(2, rd, 1'b0, 1'b0, o);
        e = sb.pop_front();
        checks++;
        if (!o.done || o.gnt !== e.gnt || o.ack !== e.ack || o.rdata !== e.rdata) begin
            failures++;
            $display("FAIL timeout_next got=gnt%b ack%b rdata%h exp=gnt%b ack%b rdata%h", o.gnt, o.ack, o.rdata, e.gnt, e.ack, e.rdata);
        end
    endtask

    task automatic test_simultaneous();
        obs_t o; exp_t e; logic [255:0] rd;
        rd = rand256();
        exp_rdata = rd;
        sb.push_back('{gnt: 4'b0010, ack: 4'b0010, err: 4'd0, rdata: rd, mem_rw: 1'b0,
                       mem_addr: 8'h20, mem_wdata: wv[1], wait_cycles: 15});
        do_txn(15, rd, 1'b0, 1'b0, o);
        req = 4'd0;
        e = sb.pop_front();
        checks++;
        if (!o.done || o.gnt !== e.gnt || o.ack !== e.ack || o.err !== e.err || o.wait_cycles != e.wait_cycles) begin
            failures++;
            $display("FAIL simul_ack got=gnt%b ack%b err%b wait%0d exp=gnt%b ack%b err%b wait%0d", o.gnt, o.ack, o.err, o.wait_cycles, e.gnt, e.ack, e.err, e.wait_cycles);
        end
        checks++;
        if (o.rdata !== e.rdata) begin
            failures++;
            $display("FAIL simul_rdata got=%h exp=%h", o.rdata, e.rdata);
        end
    endtask

    task automatic test_reset_mid_wait();
        obs_t o; exp_t e; logic [255:0] rd;
        int pulses = 0;
        req = 4'b0100;
        @(posedge clk); @(negedge clk);
        req = 4'd0;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        #2 RESET = 1'b0;
        #1;
        checks++;
        if ({gnt, ack, err, mem_en, mem_rw, mem_addr} !== 22'd0 || rdata !== 256'd0 || mem_wdata !== 256'd0) begin
            failures++;
            $display("FAIL midreset_outputs got=gnt%b ack%b err%b en%b rw%b addr%h exp=all zero", gnt, ack, err, mem_en, mem_rw, mem_addr);
        end
        mem_flag = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if ((ack | err) != 4'd0) pulses++;
        end
        mem_flag = 1'b0;
        RESET = 1'b1;
        @(negedge clk);
        @(negedge clk);
        if ((ack | err) != 4'd0) pulses++;
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL midreset_pulse got=%0d exp=0", pulses);
        end
        req = 4'b1010;
        rd = rand256();
        sb.push_back('{gnt: 4'b0010, ack: 4'b0010, err: 4'd0, rdata: rd, mem_rw: 1'b0,
                       mem_addr: 8'h20, mem_wdata: wv[1], wait_cycles: 1});
        do_txn(1, rd, 1'b0, 1'b0, o);
        req = 4'd0;
        e = sb.pop_front();
        checks++;
        if (!o.done || o.gnt !== e.gnt || o.ack !== e.ack || o.rdata !== e.rdata) begin
            failures++;
            $display("FAIL midreset_rearb got=gnt%b ack%b rdata%h exp=gnt%b ack%b rdata%h", o.gnt, o.ack, o.rdata, e.gnt, e.ack, e.rdata);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) wv[i] = rand256();
        exp_rdata = 256'd0;
        mem_rdata = 256'd0;
        test_reset();
        test_round_robin();
        test_single_read();
        test_write();
        test_timeout();
        test_simultaneous();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15, giving the maximum WAIT cycles before error (legal 1..255).
REQ-002 The block SHALL have parameter NREQ, default 4, giving the number of requesters (fixed at 4 for this release).
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port RESET, input, 1: asynchronous, active-low reset.
REQ-005 Port req, input, 4: per-requester access request (bit0 engine, bit1 mult, bit2 add/sub, bit3 transpose).
REQ-006 Port rw, input, 4: per-requester direction, 1=write, 0=read.
REQ-007 Port addr, input, 32: packed 8-bit addresses, requester k at [8k+7:8k].
REQ-008 Port wdata, input, 1024: packed 256-bit write data, requester k at [256k+255:256k].
REQ-009 Port gnt, output, 4: one-hot grant, held for the whole transaction.
REQ-010 Port ack, output, 4: one-cycle completion pulse to the granted requester.
REQ-011 Port err, output, 4: one-cycle timeout pulse to the granted requester.
REQ-012 Port rdata, output, 256: read data returned to the granted requester.
REQ-013 Ports mem_en (1), mem_rw (1), mem_addr (8) and mem_wdata (256) SHALL be outputs driving the shared memory.
REQ-014 Ports mem_rdata (256) and mem_flag (1) SHALL be inputs from the shared memory; mem_flag=1 means the access is complete.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE, WAIT and DONE, and reset into IDLE.
REQ-016 In IDLE with req!=0, the block SHALL select the first set req bit scanning upward from pointer ptr (mod 4), latch its index, rw, addr and wdata, and move to ISSUE.
REQ-017 In IDLE with req==0, the block SHALL stay in IDLE with gnt=0 and mem_en=0.
REQ-018 gnt SHALL be asserted from the ISSUE cycle through the DONE cycle inclusive, and SHALL be 0 in IDLE.
REQ-019 In ISSUE, the block SHALL drive mem_en=1 for exactly one cycle with the latched mem_rw, mem_addr and mem_wdata, then move to WAIT.
REQ-020 mem_addr, mem_rw and mem_wdata SHALL hold their latched values from ISSUE through DONE; mem_en SHALL be 0 outside ISSUE.
REQ-021 mem_flag SHALL be ignored in ISSUE and IDLE.
REQ-022 In WAIT, a 8-bit counter SHALL increment each cycle while mem_flag=0.
REQ-023 In WAIT with mem_flag=1, the block SHALL capture mem_rdata into rdata on reads only, and move to DONE.
REQ-024 On writes, rdata SHALL be left unchanged.
REQ-025 In WAIT, when the counter reaches TIMEOUT with mem_flag=0, the block SHALL set an internal timeout flag and move to DONE; if mem_flag=1 in the same cycle, the completion wins.
REQ-026 In DONE, the block SHALL pulse ack[winner] (or err[winner] on timeout) for one cycle, set ptr=winner+1 mod 4, clear the counter, and return to IDLE.
REQ-027 Minimum latency SHALL be: req seen at edge 0, ISSUE at edge 1, WAIT at edge 2, mem_flag sampled at edge 2 or later, ack in the cycle after the mem_flag sample.
REQ-028 Deasserting or changing req, rw, addr or wdata after the IDLE sample SHALL NOT abort or alter the current transaction.
REQ-029 A requester still asserting req after ack SHALL be re-arbitrated normally in the next IDLE cycle, with the rotated ptr.
REQ-030 At most one bit of gnt, ack and err SHALL be set in any cycle; ack and err SHALL never be set together.

Reset
REQ-031 RESET=0 SHALL immediately force IDLE, ptr=0, counter=0, gnt=0, ack=0, err=0, rdata=0, mem_en=0, mem_rw=0, mem_addr=0 and mem_wdata=0, regardless of clk.
REQ-032 A reset during ISSUE, WAIT or DONE SHALL drop the transaction without any ack or err pulse.
REQ-033 After RESET rises, the first arbitration SHALL start from requester 0.

Verification
REQ-034 Single read: req=0001, addr0=8'h10, mem_flag=1 on the second WAIT cycle with mem_rdata=X -> mem_en pulses once with mem_addr=8'h10 and mem_rw=0; rdata=X; ack=0001 for one cycle.
REQ-035 Round-robin: req=1111 held continuously with immediate mem_flag -> grant order 0,1,2,3,0.
REQ-036 Write: req=0100, rw=0100, wdata2=W -> mem_rw=1, mem_wdata=W, ack=0100, rdata unchanged.
REQ-037 Timeout: TIMEOUT=15, mem_flag held at 0 -> err pulses on the winner after 15 WAIT cycles, no ack, and the next arbitration skips to the following requester.
REQ-038 Simultaneous events: mem_flag rises in the same cycle the counter reaches TIMEOUT -> ack, not err.
REQ-039 Reset mid-WAIT: RESET=0 asynchronously -> all outputs 0 with no pulse; after release, req=1010 -> requester 1 is granted.
